// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the ADT7420-style I2C temperature responder.
package i2c_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6
  } state_e;

  localparam logic [7:0] REG_TEMP_MSB = 8'h00;
  localparam logic [7:0] REG_TEMP_LSB = 8'h01;
  localparam logic [7:0] REG_CFG      = 8'h03;
  localparam logic [7:0] REG_ID       = 8'h0B;
  localparam logic [7:0] CMD_SWRST    = 8'h2F;

  localparam int SYNC_LEN = 2;
  localparam int FILT_LEN = 3;

  // Two-out-of-three vote over the filter window.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Register map seen by a read at pointer ptr.
  function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                          input logic [12:0] snap,
                                          input logic [7:0]  cfg,
                                          input logic [7:0]  id);
    logic [7:0] val;
    case (ptr)
      REG_TEMP_MSB: val = snap[12:5];
      REG_TEMP_LSB: val = {snap[4:0], 3'b000};
      REG_CFG:      val = cfg;
      REG_ID:       val = id;
      default:      val = 8'h00;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Bus line conditioner: 2-flop synchronizer, 3-sample majority filter,
// registered level plus single-cycle rise/fall strobes aligned with it.
module i2c_line_filter
  import i2c_resp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_LEN-1:0] sync_r;
  logic [FILT_LEN-1:0] win_r;
  logic                maj_s;

  assign maj_s = maj3(win_r);

  // Synchronize, filter and derive edge strobes; idle bus level is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_LEN{1'b1}};
      win_r  <= {FILT_LEN{1'b1}};
      level  <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_LEN-2:0], pin};
      win_r  <= {win_r[FILT_LEN-2:0], sync_r[SYNC_LEN-1]};
      level  <= maj_s;
      rise   <= maj_s & ~level;
      fall   <= ~maj_s & level;
    end
  end

endmodule

// File: rtl/i2c_temp_responder.sv
// I2C target emulating the ADT7420 register subset used by TempSensorCtl.
// Optional build macro I2C_RESP_NACK_INJECT_EN adds the nack_inject input,
// which refuses a matching address at the ACK decision.
module i2c_temp_responder
  import i2c_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h4B,
  parameter logic [7:0] ID_VAL   = 8'hCB,
  parameter int         HOLD_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] temp_in,
  inout  logic        tmp_scl,
  inout  logic        tmp_sda,
  output logic [7:0]  cfg_reg,
  output logic        swrst_p,
  output logic        busy
`ifdef I2C_RESP_NACK_INJECT_EN
  ,
  input  logic        nack_inject
`endif
);

  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC);

  logic       scl_lvl_s, scl_rise_s, scl_fall_s;
  logic       sda_lvl_s, sda_rise_s, sda_fall_s;
  logic       start_s, stop_s, nack_s;
  logic [7:0] rd_byte_s;

  state_e      state_r;
  logic [3:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic [7:0]  tx_r;
  logic [7:0]  ptr_r;
  logic [12:0] snap_r;
  logic        rw_r;
  logic        ack_in_r;
  logic        wr_active_r;
  logic [1:0]  wr_cnt_r;
  logic        sda_low_r;
  logic        pend_low_r;
  logic [7:0]  hold_cnt_r;

  i2c_line_filter u_scl_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (tmp_scl),
    .level (scl_lvl_s),
    .rise  (scl_rise_s),
    .fall  (scl_fall_s)
  );

  i2c_line_filter u_sda_filt (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (tmp_sda),
    .level (sda_lvl_s),
    .rise  (sda_rise_s),
    .fall  (sda_fall_s)
  );

`ifdef I2C_RESP_NACK_INJECT_EN
  assign nack_s = nack_inject;
`else
  assign nack_s = 1'b0;
`endif

  assign start_s   = sda_fall_s & scl_lvl_s;
  assign stop_s    = sda_rise_s & scl_lvl_s;
  assign rd_byte_s = reg_read(ptr_r, snap_r, cfg_reg, ID_VAL);
  // Open-drain: only ever pull low, otherwise leave the line to the pull-up.
  assign tmp_sda   = sda_low_r ? 1'b0 : 1'bz;

  // Protocol FSM; SDA changes are scheduled at SCL fall and applied HOLD_CYC clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 4'd0;
      shift_r     <= 8'h00;
      tx_r        <= 8'h00;
      ptr_r       <= 8'h00;
      snap_r      <= 13'h0000;
      rw_r        <= 1'b0;
      ack_in_r    <= 1'b1;
      wr_active_r <= 1'b0;
      wr_cnt_r    <= 2'd0;
      sda_low_r   <= 1'b0;
      pend_low_r  <= 1'b0;
      hold_cnt_r  <= 8'd0;
      cfg_reg     <= 8'h00;
      swrst_p     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      swrst_p <= 1'b0;
      if (hold_cnt_r != 8'd0) begin
        hold_cnt_r <= hold_cnt_r - 8'd1;
        if (hold_cnt_r == 8'd1) sda_low_r <= pend_low_r;
      end
      if (start_s || stop_s) begin
        // A write ending with only the pointer byte 0x2F is the soft-reset command.
        if (wr_active_r && (wr_cnt_r == 2'd1) && (ptr_r == CMD_SWRST)) begin
          swrst_p <= 1'b1;
          cfg_reg <= 8'h00;
        end
        wr_active_r <= 1'b0;
        sda_low_r   <= 1'b0;
        hold_cnt_r  <= 8'd0;
        bit_cnt_r   <= 4'd0;
        busy        <= start_s;
        state_r     <= start_s ? ST_ADDR : ST_IDLE;
      end else begin
        case (state_r)
          ST_IDLE: begin
            bit_cnt_r <= 4'd0;
          end
          ST_ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_lvl_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              bit_cnt_r <= 4'd0;
              if ((shift_r[7:1] == DEV_ADDR) && !nack_s) begin
                state_r    <= ST_ADDR_ACK;
                rw_r       <= shift_r[0];
                pend_low_r <= 1'b1;
                hold_cnt_r <= HOLD_LD;
                if (shift_r[0]) begin
                  snap_r <= temp_in;
                end else begin
                  wr_active_r <= 1'b1;
                  wr_cnt_r    <= 2'd0;
                end
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_r  <= 4'd0;
              hold_cnt_r <= HOLD_LD;
              if (rw_r) begin
                state_r    <= ST_RD_BYTE;
                tx_r       <= rd_byte_s;
                pend_low_r <= ~rd_byte_s[7];
              end else begin
                state_r    <= ST_WR_BYTE;
                pend_low_r <= 1'b0;
              end
            end
          end
          ST_WR_BYTE: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[6:0], sda_lvl_s};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              // Commit only once the whole byte is in, so an aborted byte changes nothing.
              state_r    <= ST_WR_ACK;
              bit_cnt_r  <= 4'd0;
              pend_low_r <= 1'b1;
              hold_cnt_r <= HOLD_LD;
              if (wr_cnt_r == 2'd0) begin
                ptr_r <= shift_r;
              end else begin
                if (ptr_r == REG_CFG) cfg_reg <= shift_r;
                ptr_r <= ptr_r + 8'd1;
              end
              if (wr_cnt_r != 2'd2) wr_cnt_r <= wr_cnt_r + 2'd1;
            end
          end
          ST_WR_ACK: begin
            if (scl_fall_s) begin
              state_r    <= ST_WR_BYTE;
              pend_low_r <= 1'b0;
              hold_cnt_r <= HOLD_LD;
            end
          end
          ST_RD_BYTE: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              state_r    <= ST_RD_ACK;
              bit_cnt_r  <= 4'd0;
              pend_low_r <= 1'b0;
              hold_cnt_r <= HOLD_LD;
              ptr_r      <= ptr_r + 8'd1;
            end else if (scl_fall_s && (bit_cnt_r != 4'd0)) begin
              pend_low_r <= ~tx_r[3'd7 - bit_cnt_r[2:0]];
              hold_cnt_r <= HOLD_LD;
            end
          end
          ST_RD_ACK: begin
            if (scl_rise_s) begin
              ack_in_r <= sda_lvl_s;
            end else if (scl_fall_s) begin
              bit_cnt_r  <= 4'd0;
              hold_cnt_r <= HOLD_LD;
              if (!ack_in_r) begin
                state_r    <= ST_RD_BYTE;
                tx_r       <= rd_byte_s;
                pend_low_r <= ~rd_byte_s[7];
              end else begin
                state_r    <= ST_IDLE;
                pend_low_r <= 1'b0;
              end
            end
          end
          default: begin
            state_r   <= ST_IDLE;
            sda_low_r <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/i2c_temp_responder.md
# i2c_temp_responder

- I2C target that emulates the ADT7420 temperature sensor on the board's tmp_scl/tmp_sda bus.
- Serves the TempSensorCtl master that feeds temp_top: ID read, software-reset write, and repeated 2-byte temperature reads.
- Used as the sensor model in system simulation and as an on-chip loopback target; the temperature value comes from a fabric input instead of silicon.

## Interface
Parameters:
- DEV_ADDR, 7'h4B, 7-bit target address
- ID_VAL, 8'hCB, value returned from register 0x0B
- HOLD_CYC, 4, clk cycles from detected SCL fall to SDA update (≥1)

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  asynchronous active-low reset
- temp_in  input  13  two's-complement temperature, 4 fractional bits (same format as TEMP_O)
- tmp_scl  inout  1  I2C clock; never driven by this block, sampled only
- tmp_sda  inout  1  I2C data; driven 1'b0 or 'z only
- cfg_reg  output  8  last value written to register 0x03
- swrst_p  output  1  one-clk pulse on a completed write of pointer 0x2F
- busy  output  1  high from START until STOP

## Operation
- Synchronization: SCL/SDA pass through a 2-flop synchronizer, then a 3-sample majority filter. Edges are taken from the filtered signals.
- START/STOP detection has priority over every state:
  - START or repeated START: SDA falls while SCL is high. Go to ADDR, clear bit counter.
  - STOP: SDA rises while SCL is high. Go to IDLE and release SDA.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits on SCL rise. On match of addr[7:1] go to ADDR_ACK; otherwise go to IDLE, ignore the bus until the next START, and never drive SDA.
  - ADDR_ACK: drive SDA low for one SCL period. Then go to WR_BYTE if R/W=0; go to RD_BYTE if R/W=1, capturing the snapshot.
  - WR_BYTE: shift 8 bits, then go to WR_ACK. The first byte after address loads the pointer. Later bytes write the register at the pointer: only 0x03 is writable, all others are ACKed and discarded. Pointer auto-increments after each data byte.
  - WR_ACK: ACK every byte, then return to WR_BYTE.
  - RD_BYTE: drive the register at the pointer MSB-first, releasing SDA for 1 bits. Pointer increments after the byte.
  - RD_ACK: sample the master's ACK on SCL rise. ACK (SDA=0) → RD_BYTE. NACK → IDLE, wait for STOP.
- Register map, 8-bit pointer, wraps 0xFF→0x00:
  - 0x00: snap[12:5]
  - 0x01: {snap[4:0],3'b000}
  - 0x02: 8'h00
  - 0x03: cfg_reg
  - 0x0B: ID_VAL
  - others: 8'h00
- Snapshot: temp_in is latched into snap at the ADDR_ACK of a read. MSB and LSB of one transaction are therefore always coherent.
- swrst_p pulses when a write transaction ends (STOP or repeated START) with exactly one byte, the pointer, equal to 0x2F. It also sets cfg_reg to 8'h00.

## Timing
- Reset values:
  - SDA released
  - cfg_reg 8'h00
  - swrst_p 0
  - busy 0
  - state IDLE
  - pointer 8'h00
  - snap 13'h0
- Input latency is 5 clk: 2 synchronizer + 3 filter.
- SDA output changes exactly HOLD_CYC clk after the filtered SCL fall. Drive is never changed while filtered SCL is high.
- ACK drive is asserted at the SCL fall ending bit 8, and released at the SCL fall ending the ACK bit.
- busy rises the clk after START is detected and falls the clk after STOP.
- Reset mid-transfer releases SDA immediately (asynchronously). The bus is ignored until the next START.
- A repeated START mid-byte aborts the byte. Pointer and cfg_reg are unchanged.
- Bus up to 400 kHz at 100 MHz clk.

## Configuration
- I2C_RESP_NACK_INJECT_EN defined:
  - Adds input nack_inject (1 bit).
  - While high at the ADDR_ACK decision, a matching address is not ACKed: SDA stays released, state → IDLE.
  - Data bytes are unaffected.
- Undefined: the port is absent and matching addresses are always ACKed.

## Structure
- Package i2c_resp_pkg holds:
  - state enum
  - register address constants REG_TEMP_MSB, REG_TEMP_LSB, REG_CFG, REG_ID, CMD_SWRST
  - filter length constant
- One sub-module, i2c_line_filter: synchronizer + majority filter + rise/fall strobes, instantiated once each for SCL and SDA.

## Test plan
- Address only: write addr 0x4B, R/W=0, then STOP → ACK on bit 9, busy 1→0, no register change. Same with addr 0x48 → SDA never driven low.
- ID read: write ptr 0x0B, repeated START, read 1 byte with NACK → returns 0xCB, then IDLE.
- Temperature read: temp_in=13'h0191 (25.0625 °C), ptr 0x00, read 2 bytes with ACK then NACK → 0x0C, 0x88. Changing temp_in between the bytes leaves the LSB unchanged.
- Negative value: temp_in=13'h1F70 → bytes 0xFB, 0x80.
- Config/reset: write ptr 0x03 + data 0xA0 → cfg_reg=0xA0. Then write single byte 0x2F + STOP → swrst_p one clk, cfg_reg=0x00.
- Robustness:
  - Assert rst_n low mid-read-byte → SDA released within 1 clk.
  - Read at ptr 0xFF for 2 bytes → pointer wraps to 0x00.
  - With I2C_RESP_NACK_INJECT_EN and nack_inject=1 → matching address NACKed.
